// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: multi-cycle in1 - in2 (in1 + ~in2 + 1), one 4-bit slice per clock, LSB first
// Optional clamp on signed overflow: define SUB_SATURATE_EN.
module nibble_serial_subtractor #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_cout,
    output logic             o_of
);
    localparam int N  = WIDTH / SLICE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_in1;
    logic [WIDTH-1:0]   r_in2;
    logic [WIDTH-1:0]   r_diff;
    logic               r_carry;
    logic               r_cout;
    logic               r_of;
    logic [CW-1:0]      r_cnt;
    logic [BW-1:0]      w_base;
    logic [SLICE_W-1:0] w_a;
    logic [SLICE_W-1:0] w_b;
    logic [SLICE_W:0]   w_sum;
    logic               w_last;
    logic               w_ovf;

    assign w_base = BW'(r_cnt) * BW'(SLICE_W);
    assign w_a    = r_in1[w_base +: SLICE_W];
    assign w_b    = r_in2[w_base +: SLICE_W];
    assign w_sum  = {1'b0, w_a} + {1'b0, ~w_b} + {{SLICE_W{1'b0}}, r_carry};
    assign w_last = (r_cnt == CW'(N - 1));
    assign w_ovf  = (r_in1[WIDTH-1] != r_in2[WIDTH-1]) && (w_sum[SLICE_W-1] != r_in1[WIDTH-1]);

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_in_valid ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = i_out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        o_in_ready  = (r_state == IDLE);
        o_out_valid = (r_state == DONE);
    end

    // operand capture and slice-serial datapath; a reset wipes any partial result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in1   <= '0;
            r_in2   <= '0;
            r_diff  <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_of    <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == IDLE && i_in_valid) begin
            r_in1   <= i_in1;
            r_in2   <= i_in2;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_diff[w_base +: SLICE_W] <= w_sum[SLICE_W-1:0];
            r_carry <= w_sum[SLICE_W];
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_sum[SLICE_W];
                r_of   <= w_ovf;
`ifdef SUB_SATURATE_EN
                if (w_ovf) r_diff <= {r_in1[WIDTH-1], {(WIDTH-1){~r_in1[WIDTH-1]}}};
`endif
            end
        end
    end

    assign o_diff = r_diff;
    assign o_cout = r_cout;
    assign o_of   = r_of;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed vectors with a queue scoreboard checked by a handshake monitor
module tb_nibble_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [31:0] i_in1 = '0;
    logic [31:0] i_in2 = '0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [31:0] o_diff;
    logic        o_cout;
    logic        o_of;

    int total = 0;
    int bad = 0;
    logic [33:0] sb[$];

    nibble_serial_subtractor #(.WIDTH(32), .SLICE_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in1(i_in1), .i_in2(i_in2),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_diff(o_diff), .o_cout(o_cout), .o_of(o_of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: a result leaves the DUT when valid and ready meet at the coming edge
    always @(negedge clk) begin
        if (rst_n && o_out_valid && i_out_ready) begin
            if (sb.size() == 0) chk("unexpected_result", 64'(o_diff), 64'hdead);
            else begin
                logic [33:0] e;
                e = sb.pop_front();
                chk("diff", 64'(o_diff), 64'(e[33:2]));
                chk("cout", 64'(o_cout), 64'(e[1]));
                chk("of",   64'(o_of),   64'(e[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                      input logic ec, input logic eo, input int hold);
        int n;
        logic [31:0] d0;
        chk("in_ready_before", 64'(o_in_ready), 64'd1);
        i_in_valid = 1'b1;
        i_in1 = a;
        i_in2 = b;
        sb.push_back({ed, ec, eo});
        tick();
        i_in_valid = 1'b0;
        i_in1 = ~a;
        i_in2 = a ^ b;
        n = 0;
        while (!o_out_valid && n < 20) begin
            chk("in_ready_busy", 64'(o_in_ready), 64'd0);
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'd8);
        d0 = o_diff;
        for (int i = 0; i < hold; i++) begin
            i_in_valid = i[0];
            i_in1 = 32'h1111_1111 * i;
            i_in2 = 32'h0;
            tick();
            chk("hold_valid", 64'(o_out_valid), 64'd1);
            chk("hold_in_ready", 64'(o_in_ready), 64'd0);
            chk("hold_diff", 64'(o_diff), 64'(d0));
        end
        i_in_valid = 1'b0;
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        chk("valid_drop", 64'(o_out_valid), 64'd0);
        chk("in_ready_idle", 64'(o_in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_in_ready", 64'(o_in_ready), 64'd1);
        chk("rst_out_valid", 64'(o_out_valid), 64'd0);
        chk("rst_diff", 64'(o_diff), 64'd0);
        chk("rst_flags", 64'({o_cout, o_of}), 64'd0);
        rst_n = 1'b1;
        tick();
        op(32'd5, 32'd3, 32'h0000_0002, 1'b1, 1'b0, 0);
        op(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
`ifdef SUB_SATURATE_EN
        op(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 0);
        op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 5);
        op(32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 0);
`else
        op(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 0);
        op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 5);
        op(32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 0);
`endif
        op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0);
        op(32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);
        op(32'h1234_5678, 32'h1111_1111, 32'h0123_4567, 1'b1, 1'b0, 2);
        // abort mid-RUN: accepted, three slices processed, reset during slice 3
        i_in_valid = 1'b1;
        i_in1 = 32'h1234_5678;
        i_in2 = 32'h0000_0000;
        tick();
        i_in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready", 64'(o_in_ready), 64'd1);
        chk("abort_out_valid", 64'(o_out_valid), 64'd0);
        chk("abort_diff", 64'(o_diff), 64'd0);
        chk("abort_flags", 64'({o_cout, o_of}), 64'd0);
        op(32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b1, 1'b0, 0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
Multi-cycle signed/unsigned subtractor computing in1 - in2 as in1 + ~in2 + 1. It processes one 4-bit slice per clock, LSB first, with the carry held in a register between slices. It is the area-lean inverse counterpart of the combinational 32-bit carry-lookahead adder, with the same result/cout/of flag semantics. It sits behind a valid/ready operand interface and drives a valid/ready result interface.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4 and at least 8.
SLICE_W, 4, bits processed per cycle; fixed at 4.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operands present.
in_ready  output  1  block can accept operands.
in1  input  WIDTH  minuend.
in2  input  WIDTH  subtrahend.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts result.
diff  output  WIDTH  in1 - in2, two's complement.
cout  output  1  carry out of in1 + ~in2 + 1; 1 = no unsigned borrow.
of  output  1  signed overflow.

Behaviour:
- Reset, applied on a clock edge with rst_n = 0:
  - state = IDLE; in_ready = 1; out_valid = 0; diff = 0; cout = 0; of = 0.
  - Slice counter = 0; carry register = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in1 and in2; carry register = 1; slice counter = 0; go to RUN.
  - diff, cout and of keep their previous values.
- RUN:
  - in_ready = 0.
  - Each cycle, for slice k = counter: {c, s} = in1_q[4k+3:4k] + ~in2_q[4k+3:4k] + carry.
  - Write s to diff[4k+3:4k]; carry = c; counter = counter + 1.
  - On the last slice (k = WIDTH/4 - 1), in the same edge:
    - cout = c.
    - of = (in1_q[MSB] != in2_q[MSB]) && (s[3] != in1_q[MSB]).
    - Go to DONE.
- DONE:
  - out_valid = 1; diff, cout and of held stable.
  - On out_ready: out_valid = 0 on the next edge; go to IDLE.
- Latency: handshake accepted at edge T; out_valid = 1 after edge T + WIDTH/4 (8 cycles for WIDTH = 32).
- Throughput: at most one operation per WIDTH/4 + 2 cycles. in_ready = 0 during RUN and DONE.
- in_valid while not ready: ignored; the operands are not captured.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- out_ready while out_valid = 0: no effect.
- Reset mid-RUN or in DONE:
  - The operation is aborted; the reset values above apply on that edge.
  - No partial result is ever presented with out_valid = 1.
- Wrap-around: the result is modulo 2^WIDTH; cout and of report the out-of-range conditions.
- Counter width = clog2(WIDTH/4); it must not wrap inside RUN.

Optional Feature:
Macro SUB_SATURATE_EN.
- Defined: when the signed overflow condition holds on the last slice, diff is replaced on that edge:
  - with 0x7FFF...F if in1_q[MSB] = 0;
  - with 0x8000...0 if in1_q[MSB] = 1.
  - of is still reported as 1; cout is unchanged.
- Not defined: diff is the wrapped modulo result; no clamp logic is present.

Test Plan:
- 5 - 3 -> diff = 0x00000002, cout = 1, of = 0; out_valid asserted exactly 8 cycles after acceptance.
- 3 - 5 -> diff = 0xFFFFFFFE, cout = 0, of = 0.
- 0x80000000 - 0x00000001 -> cout = 1, of = 1.
  - diff = 0x7FFFFFFF without SUB_SATURATE_EN.
  - diff = 0x80000000 with SUB_SATURATE_EN.
- 0x7FFFFFFF - 0xFFFFFFFF -> cout = 0, of = 1.
  - diff = 0x80000000 without SUB_SATURATE_EN.
  - diff = 0x7FFFFFFF with SUB_SATURATE_EN.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE.
  - diff, cout and of stable; in_ready = 0; in_valid pulses ignored.
  - After out_ready = 1, the next operation is accepted 1 cycle after returning to IDLE.
- Reset mid-RUN: rst_n = 0 at slice 3 -> next edge: IDLE, in_ready = 1, out_valid = 0, diff = 0, cout = 0, of = 0. A following 0x10 - 0x01 yields 0x0000000F, cout = 1.
